// File: rtl/regmap_arb_pkg.sv
// Shared types and constants for the register-map access arbiter.
package regmap_arb_pkg;

    // Default widths of the register map this arbiter usually fronts.
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    // Width of the saturating error-response counter.
    localparam int unsigned ERR_CNT_W  = 8;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    // One register-map transaction as seen by a requester.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } reg_txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// ptr and grants the first active requester. No grant while enable is low.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    int               sum;
    logic [IDX_W-1:0] cand;

    // Walk the requesters in priority order ptr, ptr+1, ... wrapping at NUM_REQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sum = int'(ptr) + i;
            if (sum >= int'(NUM_REQ)) begin
                sum = sum - int'(NUM_REQ);
            end
            cand = IDX_W'(sum);
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/regmap_access_arbiter.sv
// Shares one register-map access port among NUM_REQ requesters. Requests
// are granted round-robin, one transaction at a time; the map strobes are
// held until ack, err or a local timeout, then a one-cycle gap carries the
// tagged response back and lets the map's hazard/timeout logic re-arm.
module regmap_access_arbiter
    import regmap_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned WAIT_LIMIT = 40,
    localparam int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             rsp_valid_o,
    output logic [ID_WIDTH-1:0]              rsp_id_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic                             rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]            reg_addr_o,
    output logic                             reg_rd_req_o,
    output logic                             reg_wr_req_o,
    output logic [DATA_WIDTH-1:0]            reg_wr_data_o,
    input  logic [DATA_WIDTH-1:0]            reg_rd_data_i,
    input  logic                             reg_ack_i,
    input  logic                             reg_err_i,
    output logic                             busy_o,
    output logic [ERR_CNT_W-1:0]             err_cnt_o
);

    // Timer must be able to count up to WAIT_LIMIT on the final ISSUE cycle.
    localparam int unsigned TIMER_W = $clog2(WAIT_LIMIT + 1);

    arb_state_e            state;
    arb_state_e            state_nxt;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  any_gnt;
    logic                  arb_en;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_nxt;

    logic [ID_WIDTH-1:0]   hold_id;
    logic                  hold_we;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;

    logic [TIMER_W-1:0]    timer;
    logic                  timer_expired;
    logic                  issue_done;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Arbitration is only live while idle; otherwise no ready is issued.
    assign arb_en  = (state == ARB_IDLE);
    assign any_gnt = |gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid_i),
        .ptr    (ptr),
        .enable (arb_en),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    // The requester after the winner gets top priority next time.
    assign ptr_nxt = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

    // Timer equals the number of ISSUE cycles already completed.
    assign timer_expired = (timer == TIMER_W'(WAIT_LIMIT - 1));
    assign issue_done    = reg_ack_i | reg_err_i | timer_expired;

    // State register; reset drops the strobes at once since they decode state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> ISSUE on any request, ISSUE -> GAP on completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (|req_valid_i) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (issue_done) begin
                    state_nxt = ARB_GAP;
                end
            end
            ARB_GAP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Output decode: ready while idle, map strobes while issuing, response in the gap.
    always_comb begin
        req_ready_o   = '0;
        reg_rd_req_o  = 1'b0;
        reg_wr_req_o  = 1'b0;
        reg_addr_o    = '0;
        reg_wr_data_o = '0;
        rsp_valid_o   = 1'b0;
        busy_o        = 1'b1;
        unique case (state)
            ARB_IDLE: begin
                req_ready_o = gnt;
                busy_o      = 1'b0;
            end
            ARB_ISSUE: begin
                reg_addr_o    = hold_addr;
                reg_wr_data_o = hold_wdata;
                reg_rd_req_o  = ~hold_we;
                reg_wr_req_o  = hold_we;
            end
            ARB_GAP: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // Winner's payload is latched on grant and held for the whole ISSUE phase.
    always_ff @(posedge clk_i) begin
        if (arb_en && any_gnt) begin
            hold_we    <= req_we_i[gnt_idx];
            hold_addr  <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            hold_wdata <= req_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pointer and response tag advance only when a grant is made.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr     <= '0;
            hold_id <= '0;
        end else if (arb_en && any_gnt) begin
            ptr     <= ptr_nxt;
            hold_id <= gnt_idx;
        end
    end

    // ISSUE-cycle timer: counts while issuing, cleared in the gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer <= '0;
        end else if (state == ARB_ISSUE) begin
            timer <= timer + TIMER_W'(1);
        end else if (state == ARB_GAP) begin
            timer <= '0;
        end
    end

    // Response capture on ISSUE exit; ack beats err, err beats the local timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_id_o      <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else if ((state == ARB_ISSUE) && issue_done) begin
            rsp_id_o <= hold_id;
            if (reg_ack_i) begin
                rsp_rdata_o   <= hold_we ? '0 : reg_rd_data_i;
                rsp_err_o     <= 1'b0;
                rsp_timeout_o <= 1'b0;
            end else if (reg_err_i) begin
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b0;
            end else begin
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b1;
            end
        end
    end

    // Error responses are tallied as they are delivered in the gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if ((state == ARB_GAP) && rsp_err_o) begin
            err_cnt_o <= sat_inc(err_cnt_o);
        end
    end

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Testbench for regmap_access_arbiter: random requesters and a scripted map
// against a transaction-level reference model.
module tb_regmap_access_arbiter;
    import regmap_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int WL = 40;

    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_NEVER = 3;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_timeout;
    logic [AW-1:0]   reg_addr;
    logic            reg_rd_req;
    logic            reg_wr_req;
    logic [DW-1:0]   reg_wr_data;
    logic [DW-1:0]   reg_rd_data;
    logic            reg_ack;
    logic            reg_err;
    logic            busy;
    logic [7:0]      err_cnt;

    logic [DW-1:0] mem [256];
    assign reg_rd_data = mem[reg_addr];

    regmap_access_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .reg_addr_o(reg_addr), .reg_rd_req_o(reg_rd_req), .reg_wr_req_o(reg_wr_req),
        .reg_wr_data_o(reg_wr_data), .reg_rd_data_i(reg_rd_data),
        .reg_ack_i(reg_ack), .reg_err_i(reg_err),
        .busy_o(busy), .err_cnt_o(err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Requester-side stimulus state
    reg_txn_t    pend   [N];
    bit          pend_v [N];
    int unsigned req_prob = 0;
    int unsigned wd_prob  = 0;
    bit          spur_en  = 1'b0;
    int          force_kind = -1;
    int          force_l    = 0;

    // Reference model: one transaction in flight, timed from its grant
    int            ptr_m;
    bit            act;
    int            cnt;
    int            resp_cyc;
    int            plan_kind;
    int            plan_l;
    reg_txn_t      m_txn;
    int            m_id;
    bit            o_err, o_to;
    logic [DW-1:0] o_rdata;
    int            errcnt_m;
    int            last_id;
    logic [DW-1:0] last_rdata;
    bit            last_err, last_to;
    int            cyc;
    int            issue_seen;
    int            grant_log [$];
    int            grant_cyc [$];
    int            rsp_cyc_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0; act = 1'b0; cnt = 0; resp_cyc = 0;
        errcnt_m = 0; last_id = 0; last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
    endtask

    // Drive requesters and the map for the current cycle (just after posedge)
    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (pend_v[k] && ($urandom_range(0, 99) < wd_prob)) begin
                pend_v[k] = 1'b0;
            end else if (!pend_v[k] && ($urandom_range(0, 99) < req_prob)) begin
                pend_v[k]       = 1'b1;
                pend[k].we      = 1'($urandom_range(0, 1));
                pend[k].addr    = 8'($urandom);
                pend[k].wdata   = 16'($urandom);
            end
            req_valid[k]             = pend_v[k];
            req_we[k]                = pend_v[k] ? pend[k].we : 1'($urandom_range(0, 1));
            req_addr[k*AW +: AW]     = pend_v[k] ? pend[k].addr : 8'($urandom);
            req_wdata[k*DW +: DW]    = pend_v[k] ? pend[k].wdata : 16'($urandom);
        end
        if (act && cnt >= 1 && cnt <= resp_cyc) begin
            reg_ack = (cnt == plan_l) && (plan_kind == K_ACK || plan_kind == K_BOTH);
            reg_err = (cnt == plan_l) && (plan_kind == K_ERR || plan_kind == K_BOTH);
        end else if (spur_en) begin
            reg_ack = 1'($urandom_range(0, 1));
            reg_err = 1'($urandom_range(0, 1));
        end else begin
            reg_ack = 1'b0;
            reg_err = 1'b0;
        end
    endtask

    // Compare all outputs against the model, then advance it (on negedge)
    task automatic check_cycle();
        logic [N-1:0] exp_ready;
        bit exp_issue, exp_rv;
        exp_ready = '0;
        if (!act) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (ptr_m + i) % N;
                if (!act && req_valid[k]) begin
                    exp_ready[k] = 1'b1;
                    act = 1'b1; cnt = 0; m_id = k; ptr_m = (k + 1) % N;
                    m_txn.we = req_we[k]; m_txn.addr = req_addr[k*AW +: AW]; m_txn.wdata = req_wdata[k*DW +: DW];
                    plan_kind = (force_kind >= 0) ? force_kind :
                                (($urandom_range(0, 9) < 6) ? K_ACK : int'($urandom_range(1, 3)));
                    plan_l    = (force_l > 0) ? force_l : int'($urandom_range(1, 6));
                    if (plan_kind == K_NEVER || plan_l > WL) begin
                        resp_cyc = WL; o_err = 1'b1; o_to = 1'b1; o_rdata = '0;
                    end else begin
                        resp_cyc = plan_l; o_to = 1'b0;
                        o_err    = (plan_kind == K_ERR);
                        o_rdata  = (o_err || m_txn.we) ? '0 : mem[m_txn.addr];
                    end
                    grant_log.push_back(k);
                    grant_cyc.push_back(cyc);
                    pend_v[k] = 1'b0;
                end
            end
        end
        exp_issue = act && cnt >= 1 && cnt <= resp_cyc;
        exp_rv    = act && cnt == resp_cyc + 1;
        if (reg_rd_req || reg_wr_req) issue_seen++;
        check_eq("ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rd_req", 32'(reg_rd_req), 32'(exp_issue && !m_txn.we));
        check_eq("wr_req", 32'(reg_wr_req), 32'(exp_issue && m_txn.we));
        check_eq("rdwr_excl", 32'(reg_rd_req && reg_wr_req), 32'(0));
        if (exp_issue) begin
            check_eq("reg_addr", 32'(reg_addr), 32'(m_txn.addr));
            check_eq("reg_wdata", 32'(reg_wr_data), 32'(m_txn.wdata));
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            last_id = m_id; last_rdata = o_rdata; last_err = o_err; last_to = o_to;
            rsp_cyc_log.push_back(cyc);
        end
        check_eq("rsp_id", 32'(rsp_id), 32'(last_id));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        check_eq("rsp_err", 32'(rsp_err), 32'(last_err));
        check_eq("rsp_timeout", 32'(rsp_timeout), 32'(last_to));
        check_eq("busy", 32'(busy), 32'(act && cnt >= 1));
        check_eq("err_cnt", 32'(err_cnt), 32'(errcnt_m));
        if (exp_rv) begin
            act = 1'b0;
            if (o_err && errcnt_m < 255) errcnt_m++;
        end else if (act) begin
            cnt++;
        end
        cyc++;
    endtask

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk); #1;
            drive_inputs();
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        reg_ack = 1'b0; reg_err = 1'b0;
        for (int k = 0; k < N; k++) pend_v[k] = 1'b0;
        req_valid = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        grant_log.delete(); grant_cyc.delete(); rsp_cyc_log.delete();
    endtask

    task automatic set_req(input int k, input bit we, input logic [7:0] addr, input logic [15:0] wdata);
        pend_v[k] = 1'b1; pend[k].we = we; pend[k].addr = addr; pend[k].wdata = wdata;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        mem[5] = 16'hA5A5;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        reg_ack = 1'b0; reg_err = 1'b0;
        for (int k = 0; k < N; k++) pend_v[k] = 1'b0;
        cyc = 0; issue_seen = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'(0));
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("rst_strobes", 32'({reg_rd_req, reg_wr_req}), 32'(0));
        check_eq("rst_addr", 32'(reg_addr), 32'(0));
        check_eq("rst_wdata", 32'(reg_wr_data), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_err_cnt", 32'(err_cnt), 32'(0));
        check_eq("rst_rsp_fields", 32'({rsp_id, rsp_rdata, rsp_err, rsp_timeout}), 32'(0));
        @(negedge clk);
        rst_ni = 1'b1;

        // Single read from requester 1, acked in the first ISSUE cycle
        force_kind = K_ACK; force_l = 1;
        set_req(1, 1'b0, 8'h05, 16'h0000);
        step(5);
        check_eq("t1_grant_id", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(1));
        check_eq("t1_latency", 32'(rsp_cyc_log.size() > 0 ? rsp_cyc_log[0] - grant_cyc[0] : -1), 32'(2));
        check_eq("t1_rsp_id", 32'(rsp_id), 32'(1));
        check_eq("t1_rdata", 32'(rsp_rdata), 32'(16'hA5A5));
        check_eq("t1_err", 32'(rsp_err), 32'(0));

        // All requesters valid continuously: order 0,1,2,3,0 at 3-cycle spacing
        do_reset();
        req_prob = 100;
        step(20);
        for (int g = 0; g < 5; g++) begin
            check_eq("t2_order", 32'(grant_log.size() > g ? grant_log[g] : -1), 32'(g % N));
            if (g > 0) check_eq("t2_spacing", 32'(grant_log.size() > g ? grant_cyc[g] - grant_cyc[g-1] : -1), 32'(3));
        end

        // Write from requester 2 answered with a map error
        do_reset();
        req_prob = 0; force_kind = K_ERR; force_l = 1;
        set_req(2, 1'b1, 8'h01, 16'h1234);
        step(6);
        check_eq("t3_rsp_id", 32'(rsp_id), 32'(2));
        check_eq("t3_err", 32'(rsp_err), 32'(1));
        check_eq("t3_rdata", 32'(rsp_rdata), 32'(0));
        check_eq("t3_timeout", 32'(rsp_timeout), 32'(0));
        check_eq("t3_err_cnt", 32'(err_cnt), 32'(1));

        // Map never answers: WAIT_LIMIT ISSUE cycles then a timeout response
        do_reset();
        force_kind = K_NEVER;
        issue_seen = 0;
        set_req(0, 1'b0, 8'h10, 16'h0000);
        step(50);
        check_eq("t4_issue_cycles", 32'(issue_seen), 32'(WL));
        check_eq("t4_err", 32'(rsp_err), 32'(1));
        check_eq("t4_timeout", 32'(rsp_timeout), 32'(1));

        // Reset asserted in the middle of ISSUE
        set_req(3, 1'b0, 8'h22, 16'h0000);
        step(6);
        check_eq("t5_in_issue", 32'(reg_rd_req), 32'(1));
        reg_ack = 1'b0; reg_err = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_strobes", 32'({reg_rd_req, reg_wr_req}), 32'(0));
        check_eq("t5_rst_busy", 32'(busy), 32'(0));
        check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("t5_rst_err_cnt", 32'(err_cnt), 32'(0));
        model_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 8'($urandom), 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        grant_log.delete(); grant_cyc.delete(); rsp_cyc_log.delete();
        force_kind = K_ACK; req_prob = 100;
        step(4);
        check_eq("t5_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(0));

        // 300 error responses saturate the error counter
        do_reset();
        force_kind = K_ERR; force_l = 1; req_prob = 100;
        step(300 * 3 + 5);
        check_eq("t6_err_cnt_sat", 32'(err_cnt), 32'(255));

        // Randomized traffic: mixed outcomes, latencies, withdrawals, stray map strobes
        do_reset();
        force_kind = -1; force_l = 0; req_prob = 30; wd_prob = 5; spur_en = 1'b1;
        step(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
